uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single serial transmitter (OUT_SERIAL_TX path) among NUM_REQ byte-stream requesters
//  (game logic, score printer, debug echo). Grants are message-granular and round-robin.
//  A grant is held from a requester's first byte until its LAST byte has fully left the transmitter.
//  The block sequences the transmitter through a START/BUSY handshake. It sits between the
//  requesters and the UART TX core.
// PARAMETERS
//  NUM_REQ         4      number of requesters (2..8)
//  IDX_W           2      index width, = clog2(NUM_REQ)
//  TIMEOUT_CYCLES  65535  idle-in-SEND cycles before a forced release (only with the macro)
// PORTS
//  CLK            in   1          system clock (25 MHz)
//  RESET          in   1          synchronous, active-high reset
//  IN_REQ_VALID   in   NUM_REQ    per-requester byte valid
//  IN_REQ_DATA    in   8*NUM_REQ  per-requester byte; slice i = [8*i+7:8*i]
//  IN_REQ_LAST    in   NUM_REQ    byte is the last of its message; qualified by VALID
//  OUT_REQ_READY  out  NUM_REQ    byte accepted when VALID&READY (combinational)
//  OUT_GRANT      out  NUM_REQ    one-hot current owner, or all zeros (registered)
//  OUT_TX_DATA    out  8          byte to transmitter (registered)
//  OUT_TX_START   out  1          1-cycle start pulse to transmitter (registered)
//  IN_TX_BUSY     in   1          transmitter busy; must rise the cycle after START
//  OUT_ARB_BUSY   out  1          high in any state other than IDLE
//  OUT_TIMEOUT    out  1          1-cycle pulse on forced release; tied 0 without the macro
// BEHAVIOUR
//  Reset values:
//   - GRANT=0, TX_DATA=8'h00, TX_START=0, TIMEOUT=0, ARB_BUSY=0, READY=0.
//   - State=IDLE, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
//  Reset mid-operation: immediate return to IDLE. A byte already in the transmitter is not aborted.
//  FSM (IDLE, SEND, WAIT_ACK, WAIT_DONE):
//   IDLE: if any VALID, pick the first valid requester searching rr_ptr+1, rr_ptr+2, ..., wrapping
//         mod NUM_REQ. Register GRANT one-hot and go to SEND (1 cycle).
//   SEND: READY[g] = !IN_TX_BUSY; all other READY bits are 0.
//         On VALID[g]&READY[g]: latch DATA[g] into TX_DATA, latch LAST[g], pulse TX_START the
//         next cycle, and go to WAIT_ACK.
//   WAIT_ACK: the single cycle in which TX_START=1. IN_TX_BUSY is ignored. Go to WAIT_DONE.
//   WAIT_DONE: hold while IN_TX_BUSY=1. On busy low:
//         - latched LAST=1: rr_ptr<=g, GRANT<=0, go to IDLE.
//         - latched LAST=0: go to SEND.
//  Latency:
//   - Request to START in IDLE with an idle transmitter: VALID at cycle 0, GRANT at cycle 1,
//     READY in cycle 1, START at cycle 2.
//   - Back-to-back bytes: next READY in the cycle after busy falls.
//  Rules:
//   - Non-granted VALIDs are ignored and never see READY.
//   - A requester must hold DATA/LAST stable while VALID=1 and READY=0.
//   - A granted requester that drops VALID before LAST keeps the grant (see the macro below).
//   - IN_TX_BUSY=1 on entry to SEND (foreign or earlier traffic) blocks READY until it falls.
//   - Two requesters valid in the same cycle: the lower distance from rr_ptr+1 wins. There is no
//     starvation: a waiter is served within NUM_REQ-1 messages.
// CONFIGURATION
//  UART_TX_ARB_TIMEOUT_EN defined:
//   - A 16-bit counter runs in SEND while VALID[g]=0 and clears on VALID[g]=1 or on leaving SEND.
//   - When the counter reaches TIMEOUT_CYCLES: GRANT<=0, rr_ptr<=g, OUT_TIMEOUT pulses 1 cycle,
//     go to IDLE.
//  Undefined: no counter; OUT_TIMEOUT=0; the grant is held indefinitely until LAST.
// TESTING
//  Bench TX model: busy rises the cycle after START and stays high 20 cycles.
//  1) Req1 sends 0x41, 0x42, 0x43 (LAST on 0x43).
//     -> 3 START pulses with TX_DATA 41, 42, 43 in order; GRANT=0010 throughout; GRANT=0000 the
//        cycle after the third busy falls.
//  2) After reset, all 4 VALID with single-byte LAST messages.
//     -> grant order 0001, 0010, 0100, 1000, then req0 again if it re-requests.
//  3) Req2 mid-message (LAST pending); req0 asserts VALID.
//     -> req0 READY=0 until req2's LAST byte completes; the next GRANT is 0001.
//  4) RESET pulsed in WAIT_DONE.
//     -> next cycle GRANT=0, START=0, TX_DATA=00, ARB_BUSY=0; with req0 and req3 both valid,
//        req0 is granted first.
//  5) IN_TX_BUSY forced high 50 cycles while req0 is granted.
//     -> READY=0 and no START for those 50 cycles; START 1 cycle after busy falls.
//  6) Macro on, TIMEOUT_CYCLES=16; req1 sends a non-last byte then drops VALID; req3 is valid.
//     -> TIMEOUT pulse 16 cycles after re-entering SEND, then GRANT=1000.
//     -> Macro off: GRANT stays 0010 for 1000 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmitter.
// Optional grant timeout: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_REQ-1:0]   IN_REQ_VALID,
  input  logic [8*NUM_REQ-1:0] IN_REQ_DATA,
  input  logic [NUM_REQ-1:0]   IN_REQ_LAST,
  output logic [NUM_REQ-1:0]   OUT_REQ_READY,
  output logic [NUM_REQ-1:0]   OUT_GRANT,
  output logic [7:0]           OUT_TX_DATA,
  output logic                 OUT_TX_START,
  input  logic                 IN_TX_BUSY,
  output logic                 OUT_ARB_BUSY,
  output logic                 OUT_TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [7:0]         txd_q, txd_d;
  logic               start_q, start_d;
  logic               last_q, last_d;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        tout_q, tout_d;
`endif

  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  int               idx;

  // First valid requester after the last owner, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(rr_q) + k) % NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && IN_REQ_VALID[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  logic       vld_g;
  logic       lst_g;
  logic [7:0] dat_g;

  assign vld_g = IN_REQ_VALID[gidx_q];
  assign lst_g = IN_REQ_LAST[gidx_q];
  assign dat_g = IN_REQ_DATA[8*gidx_q +: 8];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_d          = rr_q;
    txd_d         = txd_q;
    start_d       = 1'b0;
    last_d        = last_q;
    OUT_REQ_READY = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d         = '0;
    tout_d        = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = NUM_REQ'(1) << pick;
          gidx_d  = pick;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        OUT_REQ_READY[gidx_q] = !IN_TX_BUSY;
        if (vld_g && !IN_TX_BUSY) begin
          txd_d   = dat_g;
          last_d  = lst_g;
          start_d = 1'b1;
          state_d = S_WAIT_ACK;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (!vld_g) begin
          if (cnt_q == TO_LAST) begin
            tout_d  = 1'b1;
            grant_d = '0;
            rr_d    = gidx_q;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
`endif
      end
      S_WAIT_ACK: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!IN_TX_BUSY) begin
          if (last_q) begin
            rr_d    = gidx_q;
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= IDX_W'(NUM_REQ - 1);
      txd_q   <= 8'h00;
      start_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      txd_q   <= txd_d;
      start_q <= start_d;
      last_q  <= last_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign OUT_GRANT    = grant_q;
  assign OUT_TX_DATA  = txd_q;
  assign OUT_TX_START = start_q;
  assign OUT_ARB_BUSY = (state_q != S_IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
  assign OUT_TIMEOUT = tout_q;
`else
  assign OUT_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 20-cycle-busy
// transmitter model and per-requester byte queues.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        RESET;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  ready;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        arb_busy;
  logic        tout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ       (4),
    .IDX_W         (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK          (clk),
    .RESET        (RESET),
    .IN_REQ_VALID (req_valid),
    .IN_REQ_DATA  (req_data),
    .IN_REQ_LAST  (req_last),
    .OUT_REQ_READY(ready),
    .OUT_GRANT    (grant),
    .OUT_TX_DATA  (tx_data),
    .OUT_TX_START (tx_start),
    .IN_TX_BUSY   (tx_busy),
    .OUT_ARB_BUSY (arb_busy),
    .OUT_TIMEOUT  (tout)
  );

  // Transmitter model: busy for 20 cycles starting the cycle after START.
  int   tx_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start) tx_cnt <= 20;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_busy = force_busy || (tx_cnt > 0);

  typedef struct {
    int         cyc;
    logic [3:0] g;
    logic [7:0] d;
  } ev_t;

  logic [8:0] src_q[4][$];
  logic [3:0] en;
  logic [3:0] hs;
  logic [3:0] prev_g;
  ev_t        start_log[$];
  logic [3:0] grant_log[$];
  int         cyc, drop_cyc, tout_cyc;
  int         errors = 0;
  int         checks = 0;

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    apply();
    #1;
    hs = req_valid & ready;
    if (tx_start) start_log.push_back('{cyc, grant, tx_data});
    if (grant != 4'b0 && grant != prev_g) grant_log.push_back(grant);
    if (grant == 4'b0 && prev_g != 4'b0) drop_cyc = cyc;
    if (tout) tout_cyc = cyc;
    prev_g = grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i]) void'(src_q[i].pop_front());
    apply();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    RESET      = 1'b1;
    force_busy = 1'b0;
    en         = 4'b0;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    cycle();
    cycle();
    RESET = 1'b0;
    for (int n = 0; n < 40 && tx_busy; n++) cycle();
    start_log.delete();
    grant_log.delete();
    prev_g   = 4'b0;
    drop_cyc = -1;
    tout_cyc = -1;
    cyc      = 0;
  endtask

  task automatic run_until_idle(input string nm);
    int n;
    n = 0;
    cycle();
    while (!(src_q[0].size() == 0 && src_q[1].size() == 0 &&
             src_q[2].size() == 0 && src_q[3].size() == 0 &&
             grant == 4'b0 && !arb_busy) && n < 1000) begin
      cycle();
      n++;
    end
    cycle();
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s_idle: got busy after %0d cycles want idle", nm, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    en = 4'b0010;
    src_q[1].push_back({1'b1, 8'h99});
    RESET = 1'b1;
    cycle();
    checks++;
    if (grant !== 4'b0) begin errors++; $display("FAIL rst_grant: got %b want 0000", grant); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_txdata: got %h want 00", tx_data); end
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", tx_start); end
    checks++;
    if (arb_busy !== 1'b0) begin errors++; $display("FAIL rst_arbbusy: got %b want 0", arb_busy); end
    checks++;
    if (ready !== 4'b0) begin errors++; $display("FAIL rst_ready: got %b want 0000", ready); end
    checks++;
    if (tout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", tout); end
    RESET = 1'b0;
  endtask

  task automatic test_message();
    int bad;
    do_reset();
    src_q[1].push_back({1'b0, 8'h41});
    src_q[1].push_back({1'b0, 8'h42});
    src_q[1].push_back({1'b1, 8'h43});
    en = 4'b0010;
    apply();
    #1;
    checks++;
    if (grant !== 4'b0) begin errors++; $display("FAIL msg_c0_grant: got %b want 0000", grant); end
    cycle();
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL msg_c1_grant: got %b want 0010", grant); end
    checks++;
    if (ready !== 4'b0010) begin errors++; $display("FAIL msg_c1_ready: got %b want 0010", ready); end
    cycle();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
      errors++;
      $display("FAIL msg_c2_start: got start=%b data=%h want 1/41", tx_start, tx_data);
    end
    bad = 0;
    for (int n = 0; n < 200 && drop_cyc < 0; n++) begin
      if (grant != 4'b0 && grant != 4'b0010) bad++;
      cycle();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL msg_hold: got %0d bad cycles want 0", bad); end
    checks++;
    if (drop_cyc != 70) begin errors++; $display("FAIL msg_drop: got cycle %0d want 70", drop_cyc); end
    checks++;
    if (start_log.size() != 3) begin
      errors++;
      $display("FAIL msg_count: got %0d starts want 3", start_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (start_log[i].d !== 8'(8'h41 + i) || start_log[i].g !== 4'b0010 ||
            start_log[i].cyc != 2 + 23*i) begin
          errors++;
          $display("FAIL msg_byte%0d: got d=%h g=%b c=%0d want d=%h g=0010 c=%0d",
                   i, start_log[i].d, start_log[i].g, start_log[i].cyc, 8'h41 + i, 2 + 23*i);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 4; i++) src_q[i].push_back({1'b1, 8'(8'h10 + i)});
    en = 4'b1111;
    run_until_idle("rr1");
    src_q[0].push_back({1'b1, 8'h14});
    run_until_idle("rr2");
    checks++;
    if (grant_log.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants want 5", grant_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_log[i] !== exp_g[i]) begin
          errors++;
          $display("FAIL rr_order%0d: got %b want %b", i, grant_log[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_hold_grant();
    int bad;
    do_reset();
    src_q[2].push_back({1'b0, 8'h20});
    src_q[2].push_back({1'b1, 8'h21});
    en = 4'b0100;
    for (int n = 0; n < 50 && start_log.size() == 0; n++) cycle();
    src_q[0].push_back({1'b1, 8'h30});
    en = 4'b0101;
    bad = 0;
    for (int n = 0; n < 300 && !(src_q[2].size() == 0 && grant == 4'b0); n++) begin
      if (ready[0]) bad++;
      cycle();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_ready0: got %0d cycles want 0", bad); end
    cycle();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL hold_next: got %b want 0001", grant); end
    run_until_idle("hold");
    checks++;
    if (start_log.size() != 3 || start_log[0].d !== 8'h20 ||
        start_log[1].d !== 8'h21 || start_log[2].d !== 8'h30) begin
      errors++;
      $display("FAIL hold_bytes: got %0d starts want 20,21,30", start_log.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_q[1].push_back({1'b1, 8'h55});
    en = 4'b0010;
    for (int n = 0; n < 20 && start_log.size() == 0; n++) cycle();
    cycle();
    cycle();
    checks++;
    if (arb_busy !== 1'b1 || grant !== 4'b0010) begin
      errors++;
      $display("FAIL mid_pre: got busy=%b g=%b want 1/0010", arb_busy, grant);
    end
    RESET = 1'b1;
    cycle();
    checks++;
    if (grant !== 4'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: got g=%b s=%b d=%h b=%b want 0000/0/00/0",
               grant, tx_start, tx_data, arb_busy);
    end
    RESET = 1'b0;
    grant_log.delete();
    src_q[0].push_back({1'b1, 8'h60});
    src_q[3].push_back({1'b1, 8'h63});
    en = 4'b1001;
    run_until_idle("mid");
    checks++;
    if (grant_log.size() != 2 || grant_log[0] !== 4'b0001 || grant_log[1] !== 4'b1000) begin
      errors++;
      $display("FAIL mid_order: got %0d grants first=%b want 0001 then 1000",
               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 4'bx);
    end
  endtask

  task automatic test_busy_block();
    int bad;
    do_reset();
    force_busy = 1'b1;
    src_q[0].push_back({1'b1, 8'h77});
    en = 4'b0001;
    cycle();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL bb_grant: got %b want 0001", grant); end
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      if (ready !== 4'b0 || tx_start !== 1'b0) bad++;
      cycle();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bb_blocked: got %0d cycles want 0", bad); end
    force_busy = 1'b0;
    cycle();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h77) begin
      errors++;
      $display("FAIL bb_start: got s=%b d=%h want 1/77", tx_start, tx_data);
    end
    run_until_idle("bb");
  endtask

  task automatic test_timeout();
    do_reset();
    src_q[1].push_back({1'b0, 8'h61});
    src_q[3].push_back({1'b1, 8'h62});
    en = 4'b1010;
    for (int n = 0; n < 20 && start_log.size() == 0; n++) cycle();
    checks++;
    if (start_log.size() != 1 || start_log[0].g !== 4'b0010) begin
      errors++;
      $display("FAIL to_first: got %0d starts want 1 from 0010", start_log.size());
    end
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int n = 0; n < 200 && tout_cyc < 0; n++) cycle();
    checks++;
    if (start_log.size() == 0 || tout_cyc - start_log[0].cyc != 38) begin
      errors++;
      $display("FAIL to_pulse: got cycle %0d want start+38", tout_cyc);
    end
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL to_next: got %b want 1000", grant); end
    run_until_idle("to");
`else
    begin
      int bad_g, bad_t;
      bad_g = 0;
      bad_t = 0;
      for (int n = 0; n < 1000; n++) begin
        if (grant !== 4'b0010) bad_g++;
        if (tout !== 1'b0) bad_t++;
        cycle();
      end
      checks++;
      if (bad_g != 0) begin errors++; $display("FAIL to_hold: got %0d bad cycles want 0", bad_g); end
      checks++;
      if (bad_t != 0) begin errors++; $display("FAIL to_pulse: got %0d pulses want 0", bad_t); end
      src_q[1].push_back({1'b1, 8'h63});
      run_until_idle("to");
      checks++;
      if (grant_log.size() != 2 || grant_log[1] !== 4'b1000) begin
        errors++;
        $display("FAIL to_next: got %0d grants want second 1000", grant_log.size());
      end
    end
`endif
  endtask

  initial begin
    RESET     = 1'b1;
    en        = 4'b0;
    req_valid = 4'b0;
    req_data  = 32'h0;
    req_last  = 4'b0;
    hs        = 4'b0;
    prev_g    = 4'b0;
    cyc       = 0;
    drop_cyc  = -1;
    tout_cyc  = -1;
    @(negedge clk);
    test_reset();
    test_message();
    test_round_robin();
    test_hold_grant();
    test_reset_mid();
    test_busy_block();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
